// File: rtl/jtkicker_romslot_pkg.sv
// Shared types and constants for the kicker graphics ROM slot.
package jtkicker_romslot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BEAT0 = 2'd2,
    ST_BEAT1 = 2'd3
  } state_t;

  localparam logic CL_SCR = 1'b0;
  localparam logic CL_OBJ = 1'b1;

  localparam logic [21:0] SCR_OFFSET_DEF = 22'h00000;
  localparam logic [21:0] OBJ_OFFSET_DEF = 22'h04000;

endpackage

// File: rtl/jtkicker_romslot_cache.sv
// One-entry cache: tag/data/valid, hit compare and registered ok/data outputs.
module jtkicker_romslot_cache #(
  parameter int TW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,      // invalidate; wins over a same-cycle write
  input  logic          cs,
  input  logic [TW-1:0] addr,
  input  logic          wr,
  input  logic [TW-1:0] wr_tag,
  input  logic [31:0]   wr_data,
  output logic          hit,
  output logic          ok,
  output logic [31:0]   data
);

  logic [TW-1:0] tag;
  logic [31:0]   cdata;
  logic          valid;

  assign hit = valid && (tag == addr) && cs;

  // Cache entry: filled at the end of a burst, dropped while downloading
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      cdata <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      cdata <= wr_data;
    end
  end

  // Client-facing outputs lag the hit by one edge; data holds when missing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok   <= 1'b0;
      data <= '0;
    end else begin
      ok <= hit;
      if (hit) data <= cdata;
    end
  end

endmodule

// File: rtl/jtkicker_romslot.sv
// Graphics ROM responder: two one-entry caches sharing a 16-bit SDRAM port.
module jtkicker_romslot
  import jtkicker_romslot_pkg::*;
#(
  parameter int            AW         = 22,
  parameter logic [AW-1:0] SCR_OFFSET = AW'(SCR_OFFSET_DEF),
  parameter logic [AW-1:0] OBJ_OFFSET = AW'(OBJ_OFFSET_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [12:0]   scr_addr,
  output logic [31:0]   scr_data,
  output logic          scr_ok,
  input  logic          obj_cs,
  input  logic [13:0]   obj_addr,
  output logic [31:0]   obj_data,
  output logic          obj_ok,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_dst,
  input  logic [15:0]   sdram_din
);

  state_t        st, st_nx;
  logic          cl, cl_nx;
  logic [13:0]   lat, lat_nx;
  logic [15:0]   low, low_nx;
  logic          req_nx;
  logic [AW-1:0] addr_nx;
  logic          scr_hit, obj_hit, scr_wr, obj_wr;
  logic [AW-1:0] scr_word, obj_word;

  // 32-bit word index -> 16-bit SDRAM word address
  assign scr_word = AW'({scr_addr, 1'b0});
  assign obj_word = AW'({obj_addr, 1'b0});

  // Burst sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      cl         <= CL_SCR;
      lat        <= '0;
      low        <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      st         <= st_nx;
      cl         <= cl_nx;
      lat        <= lat_nx;
      low        <= low_nx;
      sdram_req  <= req_nx;
      sdram_addr <= addr_nx;
    end
  end

  // Arbitration (scroll first) and beat collection
  always_comb begin
    st_nx   = st;
    cl_nx   = cl;
    lat_nx  = lat;
    low_nx  = low;
    req_nx  = sdram_req;
    addr_nx = sdram_addr;
    scr_wr  = 1'b0;
    obj_wr  = 1'b0;
    case (st)
      ST_IDLE: begin
        if (!downloading) begin
          if (!scr_hit) begin
            cl_nx   = CL_SCR;
            lat_nx  = {1'b0, scr_addr};
            addr_nx = SCR_OFFSET + scr_word;
            req_nx  = 1'b1;
            st_nx   = ST_WAIT;
          end else if (obj_cs && !obj_hit) begin
            cl_nx   = CL_OBJ;
            lat_nx  = obj_addr;
            addr_nx = OBJ_OFFSET + obj_word;
            req_nx  = 1'b1;
            st_nx   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (sdram_ack) begin
          req_nx = 1'b0;
          st_nx  = ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (sdram_dst) begin
          low_nx = sdram_din;
          st_nx  = ST_BEAT1;
        end
      end
      ST_BEAT1: begin
        if (sdram_dst) begin
          st_nx = ST_IDLE;
          // a download started mid-burst makes the data stale: drop it
          if (!downloading) begin
            scr_wr = (cl == CL_SCR);
            obj_wr = (cl == CL_OBJ);
          end
        end
      end
      default: st_nx = ST_IDLE;
    endcase
  end

  jtkicker_romslot_cache #(.TW(13)) u_scr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (downloading),
    .cs      (1'b1),
    .addr    (scr_addr),
    .wr      (scr_wr),
    .wr_tag  (lat[12:0]),
    .wr_data ({sdram_din, low}),
    .hit     (scr_hit),
    .ok      (scr_ok),
    .data    (scr_data)
  );

  jtkicker_romslot_cache #(.TW(14)) u_obj (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (downloading),
    .cs      (obj_cs),
    .addr    (obj_addr),
    .wr      (obj_wr),
    .wr_tag  (lat),
    .wr_data ({sdram_din, low}),
    .hit     (obj_hit),
    .ok      (obj_ok),
    .data    (obj_data)
  );

endmodule

// File: tb/tb_jtkicker_romslot.sv
// Directed bench for jtkicker_romslot with a per-edge behavioural model.
module tb_jtkicker_romslot;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [12:0] scr_addr = '0;
  logic [31:0] scr_data;
  logic        scr_ok;
  logic        obj_cs = 1'b0;
  logic [13:0] obj_addr = '0;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 1'b0;
  logic        sdram_dst = 1'b0;
  logic [15:0] sdram_din = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  jtkicker_romslot dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .scr_addr    (scr_addr),
    .scr_data    (scr_data),
    .scr_ok      (scr_ok),
    .obj_cs      (obj_cs),
    .obj_addr    (obj_addr),
    .obj_data    (obj_data),
    .obj_ok      (obj_ok),
    .sdram_addr  (sdram_addr),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .sdram_dst   (sdram_dst),
    .sdram_din   (sdram_din)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Caches as plain (valid, tag, data) triples; one burst in flight at most.
  logic        m_sv, m_ov;
  logic [12:0] m_st;
  logic [13:0] m_ot;
  logic [31:0] m_sd, m_od;
  logic        m_busy, m_acked, m_half, m_cl;
  logic [15:0] m_low;
  logic [13:0] m_addr;
  logic        e_sok, e_ook, e_req;
  logic [31:0] e_sdat, e_odat;
  logic [21:0] e_addr;
  logic        m_sh, m_oh;

  assign m_sh = m_sv && (m_st == scr_addr);
  assign m_oh = m_ov && (m_ot == obj_addr) && obj_cs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sv <= 0; m_ov <= 0; m_st <= 0; m_ot <= 0; m_sd <= 0; m_od <= 0;
      m_busy <= 0; m_acked <= 0; m_half <= 0; m_cl <= 0; m_low <= 0; m_addr <= 0;
      e_sok <= 0; e_ook <= 0; e_req <= 0; e_sdat <= 0; e_odat <= 0; e_addr <= 0;
    end else begin
      e_sok <= m_sh;
      e_ook <= m_oh;
      if (m_sh) e_sdat <= m_sd;
      if (m_oh) e_odat <= m_od;
      if (!m_busy) begin
        if (!downloading && (!m_sh || (obj_cs && !m_oh))) begin
          m_busy <= 1; m_acked <= 0; m_half <= 0; e_req <= 1;
          if (!m_sh) begin
            m_cl <= 0; m_addr <= {1'b0, scr_addr};
            e_addr <= 22'h00000 + 22'(scr_addr) * 22'd2;
          end else begin
            m_cl <= 1; m_addr <= obj_addr;
            e_addr <= 22'h04000 + 22'(obj_addr) * 22'd2;
          end
        end
      end else if (!m_acked) begin
        if (sdram_ack) begin m_acked <= 1; e_req <= 0; end
      end else if (sdram_dst) begin
        if (!m_half) begin
          m_low <= sdram_din; m_half <= 1;
        end else begin
          m_busy <= 0;
          if (!downloading) begin
            if (!m_cl) begin m_sv <= 1; m_st <= m_addr[12:0]; m_sd <= {sdram_din, m_low}; end
            else       begin m_ov <= 1; m_ot <= m_addr;       m_od <= {sdram_din, m_low}; end
          end
        end
      end
      if (downloading) begin m_sv <= 0; m_ov <= 0; end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("scr_ok", 32'(scr_ok), 32'(e_sok));
      chk("obj_ok", 32'(obj_ok), 32'(e_ook));
      chk("sdram_req", 32'(sdram_req), 32'(e_req));
      if (e_req) chk("sdram_addr", 32'(sdram_addr), 32'(e_addr));
      if (e_sok) chk("scr_data", scr_data, e_sdat);
      if (e_ook) chk("obj_data", obj_data, e_odat);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req(input string nm, input logic [21:0] a);
    int n = 0;
    while (!sdram_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!sdram_req) begin
      total++; bad++;
      $display("FAIL %s no sdram_req within 20 cycles actual=0 required=1", nm);
    end else begin
      chk(nm, 32'(sdram_addr), 32'(a));
    end
  endtask

  task automatic ack();
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d);
    sdram_dst = 1'b1; sdram_din = d; tick(); sdram_dst = 1'b0;
  endtask

  task automatic serve(input logic [15:0] lo, input logic [15:0] hi);
    ack(); beat(lo); beat(hi);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #12;
    chk("rst_scr_ok", 32'(scr_ok), 0);
    chk("rst_obj_ok", 32'(obj_ok), 0);
    chk("rst_req", 32'(sdram_req), 0);
    chk("rst_addr", 32'(sdram_addr), 0);
    chk("rst_scr_data", scr_data, 0);
    chk("rst_obj_data", obj_data, 0);
    tick(); rst_n = 1'b1;

    // reset asserted while a request is outstanding
    wait_req("req_after_rst", 22'h00000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(sdram_req), 0);
    chk("async_rst_scr_ok", 32'(scr_ok), 0);
    chk("async_rst_obj_ok", 32'(obj_ok), 0);
    tick(); rst_n = 1'b1;
    wait_req("req_word0", 22'h00000);
    serve(16'h0001, 16'h0000);
    tick();
    chk("scr0_ok", 32'(scr_ok), 1);
    chk("scr0_data", scr_data, 32'h00000001);

    // scroll miss then hit
    scr_addr = 13'h0005;
    wait_req("scr5_addr", 22'h0000A);
    serve(16'h1234, 16'hABCD);
    chk("scr5_ok_early", 32'(scr_ok), 0);
    tick();
    chk("scr5_ok", 32'(scr_ok), 1);
    chk("scr5_data", scr_data, 32'hABCD1234);
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;   // stray ack in IDLE
    repeat (4) tick();
    chk("scr5_hold_noreq", 32'(sdram_req), 0);
    chk("scr5_hold_ok", 32'(scr_ok), 1);

    // object offset, stray strobe while waiting for ack
    obj_cs = 1'b1; obj_addr = 14'h0003;
    wait_req("obj3_addr", 22'h04006);
    beat(16'hDEAD);
    serve(16'h5678, 16'h9ABC);
    tick();
    chk("obj3_ok", 32'(obj_ok), 1);
    chk("obj3_data", obj_data, 32'h9ABC5678);
    obj_cs = 1'b0;
    tick();
    chk("obj_cs_drop", 32'(obj_ok), 0);

    // simultaneous misses: scroll first, object one IDLE cycle later
    scr_addr = 13'h0007; obj_cs = 1'b1; obj_addr = 14'h0008;
    wait_req("both_scr_addr", 22'h0000E);
    serve(16'h1111, 16'h2222);
    chk("both_idle_gap", 32'(sdram_req), 0);
    tick();
    chk("both_obj_req", 32'(sdram_req), 1);
    wait_req("both_obj_addr", 22'h04010);
    serve(16'h3333, 16'h4444);
    tick();
    chk("both_scr_ok", 32'(scr_ok), 1);
    chk("both_obj_ok", 32'(obj_ok), 1);
    chk("both_obj_data", obj_data, 32'h44443333);
    obj_cs = 1'b0;

    // address change mid-burst
    scr_addr = 13'h0005;
    wait_req("chg_req5", 22'h0000A);
    ack();
    scr_addr = 13'h0006;
    beat(16'h5555); beat(16'h6666);
    tick();
    chk("chg_ok_low", 32'(scr_ok), 0);
    wait_req("chg_req6", 22'h0000C);
    serve(16'h7777, 16'h8888);
    tick();
    chk("chg6_data", scr_data, 32'h88887777);

    // download starting mid-burst
    scr_addr = 13'h000A;
    wait_req("dl_req", 22'h00014);
    ack();
    downloading = 1'b1;
    beat(16'h9999); beat(16'hAAAA);
    repeat (5) tick();
    chk("dl_noreq", 32'(sdram_req), 0);
    chk("dl_ok_low", 32'(scr_ok), 0);
    downloading = 1'b0;
    scr_addr = 13'h0006;
    wait_req("dl_refetch", 22'h0000C);
    serve(16'hBBBB, 16'hCCCC);
    tick();
    chk("dl_refetch_ok", 32'(scr_ok), 1);
    chk("dl_refetch_data", scr_data, 32'hCCCCBBBB);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtkicker_romslot.md
Name: jtkicker_romslot

Overview:
- SDRAM-side responder for the video graphics ROM fetch interfaces: serves the scroll client (addr/data/ok) and the object client (cs/addr/data/ok).
- Each client gets a one-entry cache. Misses are arbitrated onto a single 16-bit SDRAM port, and each 32-bit result is assembled from two data beats.
- Sits between the kicker video block and the SDRAM controller, inside the game top level.

Parameters:
- AW, 22, SDRAM word-address width
- SCR_OFFSET, 22'h00000, SDRAM word base of the scroll ROM region
- OBJ_OFFSET, 22'h04000, SDRAM word base of the object ROM region

Ports:
- clk  in  1  system clock (48 MHz)
- rst_n  in  1  asynchronous, active-low reset
- downloading  in  1  ROM download in progress; blocks requests and invalidates caches
- scr_addr  in  13  scroll 32-bit word index
- scr_data  out  32  scroll data
- scr_ok  out  1  scr_data is valid for the current scr_addr
- obj_cs  in  1  object fetch request
- obj_addr  in  14  object 32-bit word index
- obj_data  out  32  object data
- obj_ok  out  1  obj_data is valid for the current obj_addr while obj_cs=1
- sdram_addr  out  AW  word address of the current burst
- sdram_req  out  1  burst request, held until sdram_ack
- sdram_ack  in  1  one-cycle pulse: request accepted
- sdram_dst  in  1  one-cycle data strobe, one per 16-bit beat
- sdram_din  in  16  SDRAM read data

Behaviour:
- Reset (async, rst_n=0): scr_ok=0, obj_ok=0, scr_data=0, obj_data=0, sdram_req=0, sdram_addr=0. Both cache valid bits=0, FSM=IDLE.
- Cache per client: tag (13 or 14 bits), 32-bit data, valid bit.
- Hit condition:
  - Scroll hit: valid && tag==scr_addr.
  - Object hit: valid && tag==obj_addr && obj_cs.
- Outputs: *_ok and *_data are registered. A hit presented at edge n gives ok=1 after edge n+1, with data = cached data.
- ok drops at the edge after the address changes to a non-matching value, or after obj_cs falls.
- Miss: the client needs service if it is not a hit. The scroll client is always active; the object client only when obj_cs=1.
- FSM states:
  - IDLE: if downloading=1, stay and clear both valid bits. Otherwise pick a client, with scroll having fixed priority over object. Latch client id and address. Set sdram_addr = OFFSET + {addr,1'b0} (AW bits, wraps mod 2^AW). Set sdram_req=1, go to WAIT.
  - WAIT: on sdram_ack, clear sdram_req and go to BEAT0.
  - BEAT0: on sdram_dst, latch sdram_din into the low half and go to BEAT1.
  - BEAT1: on sdram_dst, write {sdram_din, low} into the selected cache, set tag = latched address and valid=1, go to IDLE.
- Miss latency: address presented at edge n; sdram_req=1 after edge n+1. The cache is filled on the second-beat edge; ok=1 one edge later, provided the address still matches.
- Address change mid-burst: the burst completes and fills the cache with the latched address. ok stays 0 unless the current address equals it. A new miss is served from IDLE.
- obj_cs falling mid-burst: the burst completes and the cache is filled; obj_ok=0.
- sdram_dst in IDLE or WAIT: ignored. sdram_ack outside WAIT: ignored.
- downloading rising mid-burst: the burst completes, but no cache is written and valid bits are cleared. The FSM then holds in IDLE until downloading=0.
- Simultaneous scroll and object misses: the scroll burst goes first. The object burst is issued in the IDLE cycle right after the scroll burst, unless scroll misses again. Starvation is acceptable: the scroll client only changes address per 8 pixels.
- Back-to-back: the FSM takes one IDLE cycle between bursts.

Decomposition:
- Shared package: FSM state encoding (IDLE, WAIT, BEAT0, BEAT1), client id constants (CL_SCR=0, CL_OBJ=1), default region offsets.
- Natural sub-module: jtkicker_romslot_cache, instantiated twice (parameterised tag width). It holds tag/data/valid, does the hit compare, and registers the ok/data outputs.

Test Plan:
- Reset: hold rst_n=0 mid-burst -> sdram_req=0, scr_ok=0, obj_ok=0 immediately. After release, scr_addr=0 triggers a req at word 22'h00000.
- Scroll miss, then hit:
  - scr_addr=13'h0005 -> sdram_addr=22'h0000A.
  - Ack, then beats 16'h1234, 16'hABCD -> scr_data=32'hABCD1234, scr_ok=1 one edge after the second beat.
  - Re-presenting 13'h0005 later -> ok=1 after one edge, no sdram_req.
- Object offset: obj_cs=1, obj_addr=14'h0003 -> sdram_addr=22'h04006. obj_cs=0 -> obj_ok=0 on the next edge.
- Both clients miss in the same cycle -> scroll burst first, object req exactly one IDLE cycle after the scroll fill; both ok=1 at the end.
- scr_addr changes 5->6 between ack and beat0 -> the cache fills with tag 5, scr_ok stays 0, and a new req at 22'h0000C follows.
- downloading=1 during BEAT0 -> both beats consumed, scr_ok stays 0, no req while downloading=1. Previously cached addresses miss after downloading=0.
